// File: rtl/riscv_fetch_fifo_pkg.sv
// Shared definitions for the fetch-to-issue instruction queue: default depth,
// fetch bundle field offsets and the stored entry layout.
package riscv_fetch_fifo_pkg;

  localparam int FETCH_FIFO_DEPTH_DEFAULT = 8;
  localparam int INSTR_W                  = 32;
  localparam int FETCH_LO_INSTR           = 0;
  localparam int FETCH_HI_INSTR           = 32;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
    logic               fault;
  } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_fifo_chk.sv
// Protocol checker for the issue side: pop count must be legal and never
// exceed the number of entries presented to the decoders.
module riscv_fetch_fifo_chk #(
  parameter int PTR_W = 3
) (
  input logic             clk_i,
  input logic             rst_i,
  input logic [1:0]       issue_pop_i,
  input logic [PTR_W:0]   count_i
);

  logic [1:0] w_valid_n;

  assign w_valid_n = (count_i >= (PTR_W+1)'(2)) ? 2'd2 : count_i[1:0];

  a_pop_not_three: assert property (@(posedge clk_i) disable iff (rst_i)
    issue_pop_i != 2'd3);

  a_pop_within_valid: assert property (@(posedge clk_i) disable iff (rst_i)
    issue_pop_i <= w_valid_n);

endmodule

// File: rtl/riscv_fetch_fifo.sv
// Dual-issue instruction queue: splits 64-bit fetch bundles into single
// instructions and presents the two oldest to decode each cycle.
module riscv_fetch_fifo
  import riscv_fetch_fifo_pkg::*;
#(
  parameter int DEPTH = FETCH_FIFO_DEPTH_DEFAULT,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               fetch_valid_i,
  output logic               fetch_accept_o,
  input  logic [31:0]        fetch_pc_i,
  input  logic [63:0]        fetch_instr_i,
  input  logic               fetch_fault_i,
  output logic               issue0_valid_o,
  output logic [31:0]        issue0_pc_o,
  output logic [31:0]        issue0_instr_o,
  output logic               issue0_fault_o,
  output logic               issue1_valid_o,
  output logic [31:0]        issue1_pc_o,
  output logic [31:0]        issue1_instr_o,
  output logic               issue1_fault_o,
  input  logic [1:0]         issue_pop_i,
  output logic [PTR_W:0]     count_o
);

  // Accept is a function of count alone so fetch never sees a data-dependent stall.
  localparam logic [PTR_W:0] LP_ACCEPT_MAX = (PTR_W+1)'(DEPTH - 2);

  fetch_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W:0]     r_count;

  logic               w_push;
  logic               w_push_one;
  logic [1:0]         w_push_n;
  logic [1:0]         w_avail;
  logic [1:0]         w_pop_n;
  logic [PTR_W-1:0]   w_rd_ptr1;
  logic [INSTR_W-1:0] w_lo_instr;
  logic [INSTR_W-1:0] w_hi_instr;

  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                               input logic [1:0]       n);
    return p + PTR_W'(n);
  endfunction

  always_comb begin
    w_lo_instr = fetch_instr_i[FETCH_LO_INSTR +: INSTR_W];
    w_hi_instr = fetch_instr_i[FETCH_HI_INSTR +: INSTR_W];
    w_push     = fetch_valid_i && fetch_accept_o && !flush_i;
    w_push_one = fetch_pc_i[2];
    if (!w_push) begin
      w_push_n = 2'd0;
    end else if (w_push_one) begin
      w_push_n = 2'd1;
    end else begin
      w_push_n = 2'd2;
    end
    if (r_count >= (PTR_W+1)'(2)) begin
      w_avail = 2'd2;
    end else begin
      w_avail = r_count[1:0];
    end
    // Clamp also maps the illegal value 3 onto the available count.
    w_pop_n   = (issue_pop_i > w_avail) ? w_avail : issue_pop_i;
    w_rd_ptr1 = ptr_add(r_rd_ptr, 2'd1);
  end

  assign fetch_accept_o = (r_count <= LP_ACCEPT_MAX);
  assign count_o        = r_count;

  assign issue0_valid_o = (r_count >= (PTR_W+1)'(1));
  assign issue0_pc_o    = r_mem[r_rd_ptr].pc;
  assign issue0_instr_o = r_mem[r_rd_ptr].instr;
  assign issue0_fault_o = r_mem[r_rd_ptr].fault;
  assign issue1_valid_o = (r_count >= (PTR_W+1)'(2));
  assign issue1_pc_o    = r_mem[w_rd_ptr1].pc;
  assign issue1_instr_o = r_mem[w_rd_ptr1].instr;
  assign issue1_fault_o = r_mem[w_rd_ptr1].fault;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= ptr_add(r_wr_ptr, w_push_n);
      r_rd_ptr <= ptr_add(r_rd_ptr, w_pop_n);
      r_count  <= r_count + (PTR_W+1)'(w_push_n) - (PTR_W+1)'(w_pop_n);
    end
  end

  // Entry storage is deliberately unreset; valids gate its visibility.
  always_ff @(posedge clk_i) begin
    if (w_push && !rst_i) begin
      if (w_push_one) begin
        r_mem[r_wr_ptr] <= '{pc: fetch_pc_i, instr: w_hi_instr, fault: fetch_fault_i};
      end else begin
        r_mem[r_wr_ptr] <= '{pc: fetch_pc_i, instr: w_lo_instr, fault: fetch_fault_i};
        r_mem[ptr_add(r_wr_ptr, 2'd1)] <=
          '{pc: fetch_pc_i + 32'd4, instr: w_hi_instr, fault: fetch_fault_i};
      end
    end
  end

  riscv_fetch_fifo_chk #(.PTR_W(PTR_W)) u_chk (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .issue_pop_i (issue_pop_i),
    .count_i     (r_count)
  );

endmodule

// File: tb/tb_riscv_fetch_fifo.sv
// Directed bench for riscv_fetch_fifo: an instruction-queue model is compared
// against the outputs every cycle, plus hand-computed expectations.
module tb_riscv_fetch_fifo;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              fvalid = 1'b0;
  logic              accept;
  logic [31:0]       fpc = 32'd0;
  logic [63:0]       finstr = 64'd0;
  logic              ffault = 1'b0;
  logic              v0, f0, v1, f1;
  logic [31:0]       pc0, in0, pc1, in1;
  logic [1:0]        pop = 2'd0;
  logic [PTR_W:0]    count;

  int checks = 0;
  int errors = 0;

  ent_t q[$];
  int   m_npop;
  bit   m_acc;
  logic [31:0] exp_pc;

  riscv_fetch_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .fetch_valid_i  (fvalid),
    .fetch_accept_o (accept),
    .fetch_pc_i     (fpc),
    .fetch_instr_i  (finstr),
    .fetch_fault_i  (ffault),
    .issue0_valid_o (v0),
    .issue0_pc_o    (pc0),
    .issue0_instr_o (in0),
    .issue0_fault_o (f0),
    .issue1_valid_o (v1),
    .issue1_pc_o    (pc1),
    .issue1_instr_o (in1),
    .issue1_fault_o (f1),
    .issue_pop_i    (pop),
    .count_o        (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Queue model: pop from the front, append pushed instructions at the back.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
    end else begin
      m_acc = (DEPTH - q.size()) >= 2;
      if (flush) begin
        q.delete();
      end else begin
        m_npop = int'(pop);
        if (m_npop > 2) m_npop = 2;
        if (m_npop > q.size()) m_npop = q.size();
        repeat (m_npop) void'(q.pop_front());
        if (fvalid && m_acc) begin
          if (fpc[2]) begin
            q.push_back('{fpc, finstr[63:32], ffault});
          end else begin
            q.push_back('{fpc, finstr[31:0], ffault});
            q.push_back('{fpc + 32'd4, finstr[63:32], ffault});
          end
        end
      end
    end
  end

  // Compare DUT against the model mid-cycle.
  always @(negedge clk) begin
    check("count", 64'(count), 64'(q.size()));
    check("accept", 64'(accept), 64'((DEPTH - q.size()) >= 2));
    check("valid0", 64'(v0), 64'(q.size() >= 1));
    check("valid1", 64'(v1), 64'(q.size() >= 2));
    if (q.size() >= 1) begin
      check("pc0", 64'(pc0), 64'(q[0].pc));
      check("instr0", 64'(in0), 64'(q[0].instr));
      check("fault0", 64'(f0), 64'(q[0].fault));
    end
    if (q.size() >= 2) begin
      check("pc1", 64'(pc1), 64'(q[1].pc));
      check("instr1", 64'(in1), 64'(q[1].instr));
      check("fault1", 64'(f1), 64'(q[1].fault));
    end
  end

  task automatic drive(input logic v, input logic [31:0] p, input logic [63:0] ins,
                       input logic f, input logic [1:0] pp, input logic fl);
    fvalid = v; fpc = p; finstr = ins; ffault = f; pop = pp; flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 64'd0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst = 1'b1;
    idle();
    tick(); tick();
    check("rst_count", 64'(count), 64'd0);
    check("rst_accept", 64'(accept), 64'd1);
    check("rst_valid0", 64'(v0), 64'd0);
    check("rst_valid1", 64'(v1), 64'd0);
    rst = 1'b0;
    tick();

    // 1: aligned bundle
    drive(1'b1, 32'h0000_1000, 64'h00500093_00100013, 1'b0, 2'd0, 1'b0);
    check("t1_no_bypass", 64'(v0), 64'd0);
    tick(); idle();
    check("t1_pc0", 64'(pc0), 64'h1000);
    check("t1_in0", 64'(in0), 64'h00100013);
    check("t1_pc1", 64'(pc1), 64'h1004);
    check("t1_in1", 64'(in1), 64'h00500093);
    check("t1_count", 64'(count), 64'd2);
    pop = 2'd2; tick(); idle();
    check("t1_drained", 64'(count), 64'd0);

    // 2: misaligned bundle
    drive(1'b1, 32'h0000_2004, 64'h00208133_deadbeef, 1'b0, 2'd0, 1'b0);
    tick(); idle();
    check("t2_pc0", 64'(pc0), 64'h2004);
    check("t2_in0", 64'(in0), 64'h00208133);
    check("t2_valid1", 64'(v1), 64'd0);
    check("t2_count", 64'(count), 64'd1);
    pop = 2'd1; tick(); idle();

    // 3: fill to full, then pop with a blocked push
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h4000 + 32'(k * 8), {32'hA000_0000 + 32'(k), 32'hB000_0000 + 32'(k)},
            1'b0, 2'd0, 1'b0);
      tick();
    end
    check("t3_full_count", 64'(count), 64'd8);
    check("t3_full_accept", 64'(accept), 64'd0);
    drive(1'b1, 32'h4020, 64'h1111_1111_2222_2222, 1'b0, 2'd2, 1'b0);
    tick(); idle();
    check("t3_count", 64'(count), 64'd6);
    check("t3_accept", 64'(accept), 64'd1);
    check("t3_pc0", 64'(pc0), 64'h4008);
    check("t3_pc1", 64'(pc1), 64'h400c);
    for (int k = 0; k < 3; k++) begin
      pop = 2'd2; tick();
    end
    idle();
    check("t3_empty", 64'(count), 64'd0);

    // 4: steady stream through the pointer wrap
    drive(1'b1, 32'h5004, 64'h0000_5004_0000_0000, 1'b0, 2'd0, 1'b0);
    tick();
    exp_pc = 32'h5004;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h5008 + 32'(i * 8), {32'h0C00_0000 + 32'(i), 32'h0D00_0000 + 32'(i)},
            1'b0, (i == 0) ? 2'd1 : 2'd2, 1'b0);
      check("t4_seq0", 64'(pc0), 64'(exp_pc));
      exp_pc = exp_pc + 32'd4;
      if (i != 0) begin
        check("t4_seq1", 64'(pc1), 64'(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
      check("t4_count_range", 64'(count >= 4'd1 && count <= 4'd3), 64'd1);
      tick();
    end
    idle(); pop = 2'd2; tick(); idle();
    check("t4_empty", 64'(count), 64'd0);

    // 5: flush wins over a same-cycle push
    drive(1'b1, 32'h6000, 64'h1, 1'b0, 2'd0, 1'b0); tick();
    drive(1'b1, 32'h6008, 64'h2, 1'b0, 2'd0, 1'b0); tick();
    drive(1'b1, 32'h6014, 64'h3, 1'b0, 2'd0, 1'b0); tick();
    check("t5_count5", 64'(count), 64'd5);
    drive(1'b1, 32'h7000, 64'h4, 1'b0, 2'd0, 1'b1);
    tick(); idle();
    check("t5_count", 64'(count), 64'd0);
    check("t5_valid0", 64'(v0), 64'd0);
    check("t5_valid1", 64'(v1), 64'd0);
    tick();
    check("t5_still_empty", 64'(count), 64'd0);

    // 6: fault propagation, then asynchronous reset mid-cycle
    drive(1'b1, 32'h3000, 64'h00c0a023_00b50533, 1'b1, 2'd0, 1'b0);
    tick(); idle();
    check("t6_fault0", 64'(f0), 64'd1);
    check("t6_fault1", 64'(f1), 64'd1);
    check("t6_in0", 64'(in0), 64'h00b50533);
    drive(1'b1, 32'h8000, 64'h5, 1'b0, 2'd0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("t6_async_valid0", 64'(v0), 64'd0);
    check("t6_async_valid1", 64'(v1), 64'd0);
    check("t6_async_count", 64'(count), 64'd0);
    tick();
    check("t6_held_ignored", 64'(count), 64'd0);
    rst = 1'b0; idle();
    tick();
    check("t6_post_count", 64'(count), 64'd0);
    check("t6_post_accept", 64'(accept), 64'd1);
    drive(1'b1, 32'h9000, 64'h6, 1'b0, 2'd0, 1'b0);
    tick(); idle();
    check("t6_recover_count", 64'(count), 64'd2);
    check("t6_recover_pc0", 64'(pc0), 64'h9000);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
